fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Parametrised instruction fetch stage with a prefetch queue. Keeps a fetch PC, issues
//  one-at-a-time requests to instruction memory, buffers returned words with their PC in
//  a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
//  A redirect (branch/jump) reloads the PC, flushes the queue and squashes any in-flight response.
// PARAMETERS
//  IW        16       instruction width in bits, multiple of 8
//  AW        16       address/PC width in bits
//  DEPTH     4        queue entries, power of 2, >= 2
//  RESET_PC  'h000C   fetch PC loaded on reset, AW bits
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high
//  enable          in   1      1 = allow new memory requests
//  redirect_valid  in   1      load PC from redirect_addr, flush
//  redirect_addr   in   AW     new fetch PC
//  imem_req        out  1      request valid
//  imem_addr       out  AW     request address (= fetch PC)
//  imem_gnt        in   1      memory accepts request when imem_req & imem_gnt
//  imem_rvalid     in   1      response valid, >= 1 cycle after the grant
//  imem_rdata      in   IW     response instruction word
//  instr_valid     out  1      queue head valid
//  instr_ready     in   1      decode takes head when instr_valid & instr_ready
//  instr_data      out  IW     head instruction
//  instr_pc        out  AW     PC of head instruction
//  fill_level      out  log2(DEPTH)+1  current entry count
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, count=0, rd/wr ptr=0, outstanding=0, discard=0.
//   Outputs: imem_req=0, instr_valid=0, fill_level=0, instr_data/instr_pc=0.
//  Issue: imem_req = enable & !outstanding & !redirect_valid & (count < DEPTH).
//   Comb from registers plus the listed inputs. imem_addr=fetch_pc.
//   imem_req may drop without a grant. The memory samples only on req&gnt.
//  Grant (req&gnt): req_pc<=fetch_pc, fetch_pc<=fetch_pc+IW/8 (mod 2^AW), outstanding<=1.
//   At most one request is in flight. Response order is trivially in order.
//  Slot rule: issue only if count<DEPTH. A fill of DEPTH with an in-flight response is
//   impossible because outstanding blocks issue. An accepted response always has a free slot.
//  Response (rvalid, outstanding=1): outstanding<=0. If discard=1 or redirect_valid in the
//   same cycle: word dropped, discard<=0. Else push {req_pc, imem_rdata}.
//   rvalid with outstanding=0 is ignored.
//  Latency: rvalid in cycle N -> instr_valid=1 with that word in cycle N+1 (registered FIFO).
//   There is no bypass.
//  Pop: instr_valid = (count!=0). Head advances on valid&ready.
//   Push and pop in the same cycle: count unchanged.
//  Redirect (priority over all): fetch_pc<=redirect_addr, count<=0, pointers reset.
//   No request is issued this cycle. If outstanding=1 and no rvalid this cycle, discard<=1.
//   A pop handshake in the same cycle completes (decode keeps that word), then the queue empties.
//   Back-to-back redirects: the last one wins, discard stays set until the response arrives.
//  enable=0: no new requests. An in-flight response is still accepted. The queue still drains.
//  Reset mid-operation: all state clears immediately. A later stray rvalid is ignored
//   because outstanding=0.
// TESTING
//  1 Reset release, enable=1, gnt=1, 1-cycle rvalid, data 0xA001.. -> addr 0x000C,0x000E,..;
//    instr_pc 0x000C first, data 0xA001.
//  2 ready=0, DEPTH=4 -> exactly 4 grants, then imem_req=0; fill_level=4.
//    One pop -> one new request.
//  3 Redirect to 0x0100 while a request is in flight -> that response is dropped,
//    next instr_pc=0x0100, fill_level=0 after redirect.
//  4 Push and pop in the same cycle at count=2 -> count stays 2, order preserved.
//  5 fetch_pc=0xFFFE (AW=16) granted -> next imem_addr=0x0000.
//  6 Reset asserted with outstanding=1, then rvalid after release -> nothing enqueued,
//    imem_addr=0x000C.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: one-at-a-time memory requests feeding a DEPTH-entry
// prefetch queue of {pc, word} pairs, with redirect flush and stale-response squash.
module fetch_prefetch_queue #(
    parameter int            IW       = 16,
    parameter int            AW       = 16,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = AW'('h000C)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       redirect_valid,
    input  logic [AW-1:0]              redirect_addr,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [IW-1:0]              imem_rdata,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [IW-1:0]              instr_data,
    output logic [AW-1:0]              instr_pc,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [AW-1:0] PC_STEP = AW'(IW / 8);

    logic [AW-1:0] fetch_pc_reg;
    logic [AW-1:0] req_pc_reg;
    logic          outstanding_reg;
    logic          discard_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;

    logic [IW-1:0] data_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic grant;
    logic resp;
    logic push;
    logic pop;

    assign imem_req    = enable & ~outstanding_reg & ~redirect_valid & (count_reg < CW'(DEPTH));
    assign imem_addr   = fetch_pc_reg;
    assign grant       = imem_req & imem_gnt;
    assign resp        = imem_rvalid & outstanding_reg;
    // A response that was overtaken by a redirect (now or earlier) never enters the queue.
    assign push        = resp & ~discard_reg & ~redirect_valid;
    assign instr_valid = (count_reg != '0);
    assign pop         = instr_valid & instr_ready;
    assign fill_level  = count_reg;
    assign instr_data  = instr_valid ? data_mem[rd_ptr_reg] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : '0;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            req_pc_reg      <= '0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_addr;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            if (resp) begin
                outstanding_reg <= 1'b0;
                discard_reg     <= 1'b0;
            end else if (outstanding_reg) begin
                discard_reg <= 1'b1;
            end
        end else begin
            if (grant) begin
                req_pc_reg      <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + PC_STEP;
                outstanding_reg <= 1'b1;
            end
            if (resp) begin
                outstanding_reg <= 1'b0;
                discard_reg     <= 1'b0;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    // Storage is not reset; the outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic [2:0]  fill_level;

    fetch_prefetch_queue #(.IW(16), .AW(16), .DEPTH(DEPTH), .RESET_PC(16'h000C)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } entry_t;

    // Reference model: fetch address, one in-flight request, squash flag, and a plain queue.
    entry_t      m_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_rpc;
    bit          m_out;
    bit          m_disc;

    int passed = 0;
    int total  = 0;
    int grants = 0;
    logic [15:0] data_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_pc   = 16'h000C;
        m_rpc  = '0;
        m_out  = 0;
        m_disc = 0;
    endfunction

    task automatic check_outputs();
        bit exp_req;
        exp_req = enable && !m_out && !redirect_valid && (m_q.size() < DEPTH) && !reset;
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_q.size() != 0);
        chk("fill_level", fill_level, m_q.size());
        chk("instr_pc", instr_pc, (m_q.size() != 0) ? m_q[0].pc : 16'h0);
        chk("instr_data", instr_data, (m_q.size() != 0) ? m_q[0].data : 16'h0);
    endtask

    // One clock: check outputs for the driven inputs, advance the model, cross the edge.
    task automatic tick();
        bit req;
        bit resp;
        #2;
        check_outputs();
        if (imem_req && imem_gnt) grants++;
        req  = enable && !m_out && !redirect_valid && (m_q.size() < DEPTH);
        resp = imem_rvalid && m_out;
        if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_addr;
            if (resp) begin
                m_out  = 0;
                m_disc = 0;
            end else if (m_out) begin
                m_disc = 1;
            end
        end else if (req && imem_gnt) begin
            m_rpc = m_pc;
            m_pc  = m_pc + 16'd2;
            m_out = 1;
        end else if (resp) begin
            if (!m_disc) m_q.push_back('{pc: m_rpc, data: imem_rdata});
            m_out  = 0;
            m_disc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        enable = 0; redirect_valid = 0; redirect_addr = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
    endtask

    // Asserts reset between edges so its asynchronous effect is observed before any edge.
    task automatic do_reset();
        clear_inputs();
        reset = 1;
        #2;
        m_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic respond_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            imem_rvalid = m_out;
            imem_rdata  = data_ctr;
            if (m_out) data_ctr++;
            tick();
        end
        imem_rvalid = 0;
    endtask

    initial begin
        m_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetch from the reset PC with a fast memory
        enable = 1; imem_gnt = 1; instr_ready = 0; data_ctr = 16'hA001; grants = 0;
        chk("t1_addr0", imem_addr, 16'h000C);
        tick();
        chk("t1_addr1", imem_addr, 16'h000E);
        imem_rvalid = 1; imem_rdata = data_ctr; data_ctr++;
        tick();
        imem_rvalid = 0;
        chk("t1_first_pc", instr_pc, 16'h000C);
        chk("t1_first_data", instr_data, 16'hA001);
        respond_cycles(12);

        // Queue full with decode stalled
        chk("t2_grants", grants, 4);
        chk("t2_full", fill_level, 3'd4);
        chk("t2_req_off", imem_req, 1'b0);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        respond_cycles(4);
        chk("t2_one_more", grants, 5);
        chk("t2_refull", fill_level, 3'd4);

        // Simultaneous push and pop at two entries
        enable = 0; instr_ready = 1;
        tick();
        tick();
        instr_ready = 0; enable = 1;
        tick();
        enable = 0; imem_rvalid = 1; imem_rdata = 16'hC0DE; instr_ready = 1;
        tick();
        imem_rvalid = 0; instr_ready = 0;
        chk("t4_count_kept", fill_level, 3'd2);
        instr_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        instr_ready = 0;

        // Redirect while a request is in flight
        enable = 1; imem_gnt = 1;
        tick();
        redirect_valid = 1; redirect_addr = 16'h0100;
        tick();
        redirect_valid = 0;
        chk("t3_flushed", fill_level, 3'd0);
        chk("t3_new_addr", imem_addr, 16'h0100);
        imem_rvalid = 1; imem_rdata = 16'hDEAD;
        tick();
        imem_rvalid = 0;
        chk("t3_dropped", fill_level, 3'd0);
        tick();
        imem_rvalid = 1; imem_rdata = 16'hBEEF;
        tick();
        imem_rvalid = 0;
        chk("t3_pc", instr_pc, 16'h0100);
        chk("t3_data", instr_data, 16'hBEEF);

        // PC wraps at the top of the address space
        redirect_valid = 1; redirect_addr = 16'hFFFE;
        tick();
        redirect_valid = 0;
        tick();
        chk("t5_wrap", imem_addr, 16'h0000);
        enable = 0; imem_rvalid = 1; imem_rdata = 16'h1234;
        tick();
        imem_rvalid = 0;

        // Reset while a request is outstanding, stray response afterwards
        enable = 1;
        tick();
        do_reset();
        imem_rvalid = 1; imem_rdata = 16'h1111;
        tick();
        imem_rvalid = 0;
        chk("t6_empty", fill_level, 3'd0);
        chk("t6_addr", imem_addr, 16'h000C);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable         = ($urandom_range(0, 9) < 8);
            imem_gnt       = ($urandom_range(0, 9) < 7);
            imem_rvalid    = $urandom_range(0, 1);
            imem_rdata     = 16'($urandom);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_addr  = 16'($urandom_range(0, 32767) * 2);
            instr_ready    = $urandom_range(0, 1);
            tick();
        end
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
